// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// frame length and baud divisor helpers.
package uart_pkg;

  // Legacy-compatible state encodings; the enum below reuses them
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_SEND = S_SEND
  } state_e;

  // Start + data + parity + stop
  function automatic int frame_bits(input int data_width);
    return data_width + 3;
  endfunction

  // Clock cycles per bit period (integer divide, caller guarantees >= 2)
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and raises tick
// on the last count of each period. clear restarts the period at 0.
module uart_baud_gen #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt_reg;

  assign tick = en && (baud_cnt_reg == LAST);

  // Wrapping period counter with synchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt_reg <= '0;
    end else if (clear) begin
      baud_cnt_reg <= '0;
    end else if (en) begin
      baud_cnt_reg <= (baud_cnt_reg == LAST) ? '0 : baud_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte on valid/ready, strobes the
// shifter's load and shift_en, counts frame bits and pulses done at the
// end of the stop bit. Define UART_TX_HOLD_EN to add a one-entry holding
// register that allows back-to-back frames.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_BITS = frame_bits(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  load,
  output logic                  shift_en,
  output logic [DATA_WIDTH-1:0] shift_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int BW       = $clog2(FRAME_BITS + 1);

  state_e                state_reg, state_next;
  logic [BW-1:0]         bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_data_reg;
  logic                  tick, accept, restart, baud_clear, baud_en;

  // Outputs decode straight from state so an async reset clears them at once
  assign baud_clear = (state_reg == ST_LOAD);
  assign baud_en    = (state_reg == ST_SEND);
  assign load       = (state_reg == ST_LOAD);
  assign busy       = (state_reg != ST_IDLE);
  assign shift_en   = tick;
  assign done       = tick && (bit_cnt_reg == BW'(FRAME_BITS - 1));
  assign accept     = tx_valid && tx_ready;
  assign shift_data = shift_data_reg;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .en    (baud_en),
    .tick  (tick)
  );

`ifdef UART_TX_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_data_reg;
  logic                  hold_full_reg;

  assign tx_ready = !hold_full_reg;
  // A pending byte (held, or offered on the done cycle) starts the next frame
  assign restart  = hold_full_reg || accept;

  // Holding register: filled while a frame is in flight, drained at done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data_reg <= '0;
      hold_full_reg <= 1'b0;
    end else if (done) begin
      hold_full_reg <= 1'b0;
    end else if (accept && (state_reg != ST_IDLE)) begin
      hold_data_reg <= tx_data;
      hold_full_reg <= 1'b1;
    end
  end

  // Shifter byte: direct capture in IDLE, or next byte at the done cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_data_reg <= '0;
    end else if ((state_reg == ST_IDLE) && accept) begin
      shift_data_reg <= tx_data;
    end else if (done && hold_full_reg) begin
      shift_data_reg <= hold_data_reg;
    end else if (done && accept) begin
      shift_data_reg <= tx_data;
    end
  end
`else
  assign tx_ready = (state_reg == ST_IDLE);
  assign restart  = 1'b0;

  // Shifter byte: captured only on acceptance in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_data_reg <= '0;
    end else if (accept) begin
      shift_data_reg <= tx_data;
    end
  end
`endif

  // Frame bit counter: cleared in LOAD, advances on every bit period end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_reg <= '0;
    end else if (state_reg == ST_LOAD) begin
      bit_cnt_reg <= '0;
    end else if (shift_en) begin
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: if (done) state_next = restart ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl (BAUD_DIV=4, FRAME_BITS=11).
// Hold-register scenarios are compiled in when UART_TX_HOLD_EN is defined.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, load, shift_en, busy, done;
  logic [7:0] shift_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  int f_pulses, f_first, f_badgap, f_done_t, f_extra_load, f_overlap;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .CLK_FREQ   (40),
    .BAUD_RATE  (10),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .load       (load),
    .shift_en   (shift_en),
    .shift_data (shift_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at the load cycle; returns at the done cycle (or after the bound)
  task automatic frame(input logic [7:0] exp, input string tag,
                       input int offer_t, input logic [7:0] offer_data);
    int last;
    check({tag, "_load"}, 32'(load), 32'd1);
    check({tag, "_data"}, 32'(shift_data), 32'(exp));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    f_pulses = 0; f_first = 0; f_badgap = 0; f_done_t = 0;
    f_extra_load = 0; f_overlap = 0; last = 0;
    for (int t = 1; t <= 60; t++) begin
      if (t == offer_t) begin
        tx_valid = 1'b1;
        tx_data  = offer_data;
      end
      step();
      if (t == offer_t) begin
        tx_valid = 1'b0;
        check({tag, "_ready_offer"}, 32'(tx_ready), 32'd0);
      end
      if (shift_en) begin
        f_pulses++;
        if (f_pulses == 1) f_first = t;
        else if (t - last != 4) f_badgap++;
        last = t;
      end
      if (load) begin
        f_extra_load++;
        if (shift_en) f_overlap++;
      end
      if (done) begin
        f_done_t = t;
        break;
      end
    end
    check({tag, "_pulses"}, 32'(f_pulses), 32'd11);
    check({tag, "_first"}, 32'(f_first), 32'd4);
    check({tag, "_gaps"}, 32'(f_badgap), 32'd0);
    check({tag, "_done_t"}, 32'(f_done_t), 32'd44);
    check({tag, "_done_shift"}, 32'(shift_en), 32'd1);
    check({tag, "_noload"}, 32'(f_extra_load + f_overlap), 32'd0);
    check({tag, "_data_end"}, 32'(shift_data), 32'(exp));
  endtask

  task automatic wait_load(input string tag);
    int found = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (load) begin
        found = 1;
        break;
      end
    end
    check({tag, "_found"}, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d;
    // Reset state
    #2;
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_shift", 32'(shift_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(shift_data), 32'd0);
    #20 rst = 1'b1;
    step();
    check("idle_ready", 32'(tx_ready), 32'd1);

    // 1: single frame, tx_data changed after acceptance
    tx_valid = 1'b1; tx_data = 8'hA5;
    step();
    tx_valid = 1'b0; tx_data = 8'hFF;
    frame(8'hA5, "t1", -1, 8'h00);
    step();
    check("t1_ready_after", 32'(tx_ready), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);

`ifndef UART_TX_HOLD_EN
    // 2: backpressure while a frame is in flight
    tx_valid = 1'b1; tx_data = 8'hC3;
    step();
    tx_data = 8'h3C;
    check("t2_ready_load", 32'(tx_ready), 32'd0);
    frame(8'hC3, "t2a", -1, 8'h00);
    check("t2_ready_done", 32'(tx_ready), 32'd0);
    step();
    check("t2_idle_load", 32'(load), 32'd0);
    check("t2_idle_ready", 32'(tx_ready), 32'd1);
    step();
    tx_valid = 1'b0;
    frame(8'h3C, "t2b", -1, 8'h00);
    step();
`endif

    // 3: async reset 20 cycles into a frame
    tx_valid = 1'b1; tx_data = 8'h77;
    step();
    tx_valid = 1'b0;
    check("t3_load", 32'(load), 32'd1);
    repeat (20) step();
    check("t3_busy_pre", 32'(busy), 32'd1);
    check("t3_shift_pre", 32'(shift_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t3_busy_rst", 32'(busy), 32'd0);
    check("t3_shift_rst", 32'(shift_en), 32'd0);
    check("t3_done_rst", 32'(done), 32'd0);
    check("t3_ready_rst", 32'(tx_ready), 32'd1);
    d = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) d++;
    end
    check("t3_no_done", 32'(d), 32'd0);
    rst = 1'b1;
    step();
    check("t3_idle", 32'(busy), 32'd0);
    tx_valid = 1'b1; tx_data = 8'h0F;
    step();
    tx_valid = 1'b0;
    frame(8'h0F, "t3b", -1, 8'h00);
    step();

    // 4: continuous traffic 00, FF, 55
    tx_valid = 1'b1; tx_data = 8'h00;
    step();
    tx_data = 8'hFF;
    frame(8'h00, "t4a", -1, 8'h00);
    wait_load("t4b");
    tx_data = 8'h55;
    frame(8'hFF, "t4b", -1, 8'h00);
    wait_load("t4c");
    tx_valid = 1'b0;
    frame(8'h55, "t4c", -1, 8'h00);
    step();
    check("t4_idle", 32'(busy), 32'd0);

`ifdef UART_TX_HOLD_EN
    // 5: second byte captured into hold mid-frame
    tx_valid = 1'b1; tx_data = 8'h11;
    step();
    tx_valid = 1'b0;
    frame(8'h11, "t5a", 5, 8'h22);
    check("t5_ready_done", 32'(tx_ready), 32'd0);
    step();
    check("t5_reload", 32'(load), 32'd1);
    check("t5_reload_data", 32'(shift_data), 32'h22);
    frame(8'h22, "t5b", -1, 8'h00);

    // 6: byte offered on the done cycle with hold empty
    check("t6_ready_done", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1; tx_data = 8'h33;
    step();
    tx_valid = 1'b0;
    check("t6_reload", 32'(load), 32'd1);
    frame(8'h33, "t6", -1, 8'h00);
    step();
    check("t6_idle", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
